// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM link: lane width, slot encodings and receive FSM states.
// The slot constants must match the selector encoding used on the transmit side.
package tdm_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] SLOT_A = 2'b00;
    localparam logic [1:0] SLOT_B = 2'b01;
    localparam logic [1:0] SLOT_C = 2'b10;
    localparam logic [1:0] SLOT_D = 2'b11;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sync_state_t;

endpackage

// File: rtl/tdm_frame_sync.sv
// Frame synchroniser: tracks slot position from SYNC, drives staging write-enables and the commit strobe.
// Framing violations produce a one-cycle error pulse; a missing sync on slot 0 drops lock.
module tdm_frame_sync
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic       sync,
    output logic [1:0] sel,
    output logic       lock,
    output logic [2:0] stage_we,
    output logic       commit,
    output logic       sync_err
);

    sync_state_t state, state_next;
    logic [1:0]  sel_next;
    logic        err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            sel      <= SLOT_A;
            sync_err <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            state    <= state_next;
            sel      <= sel_next;
            sync_err <= err_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        stage_we   = 3'b000;
        commit     = 1'b0;
        err_next   = 1'b0;

        if (valid) begin
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        stage_we[0] = 1'b1;
                        sel_next    = SLOT_B;
                        state_next  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // A sync away from slot 0 restarts the frame on this beat.
                        err_next    = (sel != SLOT_A);
                        stage_we[0] = 1'b1;
                        sel_next    = SLOT_B;
                    end else begin
                        unique case (sel)
                            SLOT_A: begin
                                err_next   = 1'b1;
                                sel_next   = SLOT_A;
                                state_next = HUNT;
                            end
                            SLOT_B: begin
                                stage_we[1] = 1'b1;
                                sel_next    = SLOT_C;
                            end
                            SLOT_C: begin
                                stage_we[2] = 1'b1;
                                sel_next    = SLOT_D;
                            end
                            SLOT_D: begin
                                commit   = 1'b1;
                                sel_next = SLOT_A;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign lock = (state == LOCKED);

endmodule

// File: rtl/tdm_demux_1_4.sv
// Receive side of the 4-to-1 TDM link: stages slots A..C and commits all four outputs together
// on the slot-D beat, so A..D always hold one complete frame.
module tdm_demux_1_4
    import tdm_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] DIN,
    input  logic         VALID,
    input  logic         SYNC,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] C,
    output logic [W-1:0] D,
    output logic [1:0]   SEL,
    output logic         LOCK,
    output logic         FRAME_DONE,
    output logic         SYNC_ERR
);

    logic [W-1:0] stage [0:2];
    logic [2:0]   stage_we;
    logic         commit;

    tdm_frame_sync u_frame_sync (
        .clk      (CLK),
        .rst      (RST),
        .valid    (VALID),
        .sync     (SYNC),
        .sel      (SEL),
        .lock     (LOCK),
        .stage_we (stage_we),
        .commit   (commit),
        .sync_err (SYNC_ERR)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the staging array is only three words, so it is cleared on reset like the outputs.
            for (int i = 0; i < 3; i++) stage[i] <= '0;
            A          <= '0;
            B          <= '0;
            C          <= '0;
            D          <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= commit;
            for (int i = 0; i < 3; i++) begin
                if (stage_we[i]) stage[i] <= DIN;
            end
            // Slot D bypasses staging so the frame lands one cycle after its last beat.
            if (commit) begin
                A <= stage[0];
                B <= stage[1];
                C <= stage[2];
                D <= DIN;
            end
        end
    end

endmodule
